// File: rtl/joy_db15_responder.sv
// Device side of the DB15 two-player 74HC165-chain adapter. It snapshots both
// button vectors while LOAD is low and shifts them out on JOY_CLK rising edges.
module joy_db15_responder #(
  parameter int BITS_PER_PLAYER = 12,
  parameter int FILT            = 3
) (
  input  logic                       clk,
  input  logic                       reset_n,
  input  logic                       joy_clk_i,
  input  logic                       joy_load_i,
  output logic                       joy_data_o,
  input  logic [BITS_PER_PLAYER-1:0] player1_i,
  input  logic [BITS_PER_PLAYER-1:0] player2_i,
  output logic                       frame_done_o,
  output logic                       bad_frame_o,
  output logic                       busy_o
);

  localparam int W  = 2 * BITS_PER_PLAYER;
  localparam int PW = $clog2(W + 1);
  localparam int CW = (FILT > 0) ? $clog2(FILT + 1) : 1;
  localparam logic [PW-1:0] PTR_LAST = PW'(W);

  // Channel index into the synchronizer/filter arrays.
  localparam int CH_CLK  = 0;
  localparam int CH_LOAD = 1;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_LOAD  = 2'd1,
    ST_SHIFT = 2'd2,
    ST_DONE  = 2'd3
  } state_e;

  // Idle line levels: shift clock low, load released (high).
  localparam logic [1:0] IDLE_LEVELS = 2'b10;

  logic [1:0]    sync1_q, sync2_q;
  logic [1:0]    filt_q, filt_d;
  logic [CW-1:0] cnt_q [2];
  logic [CW-1:0] cnt_d [2];

  state_e        state_q, state_d;
  logic [W-1:0]  shreg_q, shreg_d;
  logic [PW-1:0] ptr_q, ptr_d;
  logic          data_q, data_d;
  logic          done_q, done_d;
  logic          bad_q, bad_d;

  logic [W-1:0]  frame_word;
  logic          load_lvl;
  logic          clk_rise;

  // NOTE: sequential state is updated with non-blocking assignments only, so
  // every flop samples the pre-edge value of every other flop.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync1_q <= IDLE_LEVELS;
      sync2_q <= IDLE_LEVELS;
      filt_q  <= IDLE_LEVELS;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= {joy_load_i, joy_clk_i};
      sync2_q <= sync1_q;
      filt_q  <= filt_d;
      cnt_q   <= cnt_d;
    end
  end

  // A synchronized level must differ from the accepted one for FILT+1
  // consecutive cycles before it replaces it; shorter pulses reset the count.
  // NOTE: every always_comb output gets a default first so no latch is inferred.
  always_comb begin
    filt_d = filt_q;
    cnt_d  = '{default: '0};
    for (int i = 0; i < 2; i++) begin
      if (sync2_q[i] != filt_q[i]) begin
        if (int'(cnt_q[i]) >= FILT) begin
          filt_d[i] = sync2_q[i];
        end else begin
          cnt_d[i] = cnt_q[i] + 1'b1;
        end
      end
    end
  end

  // Edges are taken from the filter's next value so the output register
  // is the only stage after the filter.
  assign load_lvl   = filt_d[CH_LOAD];
  assign clk_rise   = filt_d[CH_CLK] & ~filt_q[CH_CLK];
  assign frame_word = {~player2_i, ~player1_i};

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= ST_IDLE;
      shreg_q <= '1;
      ptr_q   <= '0;
      data_q  <= 1'b1;
      done_q  <= 1'b0;
      bad_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      shreg_q <= shreg_d;
      ptr_q   <= ptr_d;
      data_q  <= data_d;
      done_q  <= done_d;
      bad_q   <= bad_d;
    end
  end

  always_comb begin
    state_d = state_q;
    shreg_d = shreg_q;
    ptr_d   = ptr_q;
    data_d  = data_q;
    done_d  = 1'b0;
    bad_d   = 1'b0;

    if (!load_lvl) begin
      // Load low overrides everything, including a coincident clock edge.
      state_d = ST_LOAD;
      shreg_d = frame_word;
      ptr_d   = '0;
      data_d  = frame_word[0];
      if (state_q == ST_SHIFT && ptr_q != '0) begin
        bad_d = 1'b1;
      end
    end else begin
      unique case (state_q)
        ST_IDLE: begin
          data_d = 1'b1;
        end
        ST_LOAD: begin
          // Load release; a clock edge in this same cycle is dropped.
          state_d = ST_SHIFT;
          data_d  = shreg_q[0];
        end
        ST_SHIFT: begin
          if (clk_rise) begin
            shreg_d = {1'b1, shreg_q[W-1:1]};
            ptr_d   = ptr_q + 1'b1;
            data_d  = shreg_d[0];
            if (ptr_d == PTR_LAST) begin
              state_d = ST_DONE;
              done_d  = 1'b1;
              data_d  = 1'b1;
            end
          end
        end
        ST_DONE: begin
          data_d = 1'b1;
        end
        default: begin
          state_d = ST_IDLE;
          data_d  = 1'b1;
        end
      endcase
    end
  end

  assign joy_data_o   = data_q;
  assign frame_done_o = done_q;
  assign bad_frame_o  = bad_q;
  assign busy_o       = (state_q == ST_SHIFT);

endmodule

// File: doc/joy_db15_responder.md
Name: joy_db15_responder

Overview:
- Device-side model of the DB15 two-player serial adapter (74HC165 chain). It answers the JOY_CLK / JOY_LOAD / JOY_DATA protocol that the core-side DB15 reader drives.
- Takes two player button vectors, snapshots them on LOAD, and shifts them out serially on JOY_CLK rising edges.
- Used as a loopback/bench partner for the reader, and on the USER port of a MiSTer acting as a pad source for another board.

Parameters:
- BITS_PER_PLAYER, 12, number of button bits per player (bit 0 = R, 1 = L, 2 = D, 3 = U, 4.. = buttons).
- FILT, 3, clock cycles a synchronized JOY_CLK / JOY_LOAD level must be stable before it is accepted (glitch filter; 0 = no filter).

Ports:
- clk  in  1  system clock, 40-50 MHz (CLK_JOY domain).
- reset_n  in  1  asynchronous, active-low reset.
- joy_clk_i  in  1  shift clock from the reader, asynchronous; a rising edge advances one bit.
- joy_load_i  in  1  parallel load from the reader, asynchronous, active-low (low = load/transparent).
- joy_data_o  out  1  serial data to the reader; line level is active-low (pressed = 0).
- player1_i  in  BITS_PER_PLAYER  player 1 buttons, active-high, clk domain.
- player2_i  in  BITS_PER_PLAYER  player 2 buttons, active-high, clk domain.
- frame_done_o  out  1  one-cycle pulse after the last of 2*BITS_PER_PLAYER bits is shifted.
- bad_frame_o  out  1  one-cycle pulse when a load arrives mid-frame (frame aborted).
- busy_o  out  1  high while in SHIFT.

Behaviour:
- Synchronizer: two-flop synchronizer on joy_clk_i and joy_load_i, then a FILT-cycle stability filter. Edge detection uses filtered levels only.
- Frame word: W = 2*BITS_PER_PLAYER bits = {~player2_i, ~player1_i}. Bit 0 (~player1_i[0]) goes out first. Player 2 bits follow player 1, LSB first.
- Reset: joy_data_o = 1, frame_done_o = 0, bad_frame_o = 0, busy_o = 0. Shift register all 1s, bit pointer 0, state IDLE. Filtered levels reset to clk = 0, load = 1.
- States:
  - IDLE: joy_data_o = 1.
  - LOAD:
    - Entered whenever filtered load = 0, from any state.
    - The shift register reloads from W every clk cycle (transparent, like the 165). joy_data_o = W[0]; pointer = 0.
    - JOY_CLK edges are ignored while load = 0.
  - SHIFT:
    - Entered on filtered load 0->1.
    - Each filtered joy_clk rising edge shifts right by one, fill = 1, and increments the pointer. joy_data_o = shreg[0], registered.
    - When the pointer reaches W (the W-th edge), go to DONE and pulse frame_done_o in the same cycle the pointer hits W.
  - DONE: joy_data_o = 1 (fill). Further clk edges keep it 1. Load low -> LOAD.
- Abort: load going low while in SHIFT with pointer in 1..W-1 pulses bad_frame_o once, then goes to LOAD. Load low in SHIFT at pointer 0 is not an abort.
- Latency: joy_data_o updates 2 (sync) + FILT + 1 clk cycles after a joy_clk rising edge or load edge. Worst case at FILT = 3 is 6 cycles, 125 ns at 48 MHz. The reader's half-period must exceed this.
- Simultaneous events: load falling in the same filtered cycle as a clk rise means load wins (no shift, no frame_done_o). A clk rise in the same cycle as load rising is ignored; shifting starts on the next clk rise.
- Glitches: pulses on either input shorter than FILT+1 cycles produce no state change.
- busy_o = 1 only in SHIFT.
- Input vectors are sampled only during LOAD. Changes while in SHIFT do not affect the frame in flight.
- Reset mid-frame: immediate return to IDLE values; no pulses emitted.

Test Plan:
- Reset with reset_n = 0 and toggling inputs -> joy_data_o = 1, all pulses 0, busy_o = 0; after release the outputs hold until the first load.
- player1_i = 12'h011, player2_i = 12'h800; load low 20 cycles, then high; 24 clk rises at 1 MHz -> serial bits 0,1,1,1,0,1,1,1,1,1,1,1, then 1x11, then 0. frame_done_o pulses once after edge 24; the 25th edge keeps joy_data_o = 1.
- Load pulsed low after 5 clk edges -> bad_frame_o pulses once. The next frame restarts at bit 0 with freshly sampled inputs.
- 2-cycle glitch on joy_clk_i (FILT = 3) -> no shift; serial stream identical to the glitch-free run.
- player1_i changes from 0 to 12'hFFF during SHIFT at edge 3 -> the remaining bits still reflect the value latched at load (all 1s on the line).
- Load release coincident with a clk rise -> no shift on that edge; the first bit is held until the next rise; a 24-edge frame completes with a frame_done_o pulse.
